// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Brief    : Burst-locked round-robin arbiter feeding one registered stream stage.
// Revision : 1.0
// ============================================================================
module stream_rr_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int BURST = 4,
  parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    up_valid,
  output logic [N-1:0]    up_ready,
  input  logic [N*DW-1:0] up_data,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [DW-1:0]   down_data,
  output logic [IW-1:0]   down_src
);

  localparam logic [15:0]   c_burst    = 16'(BURST);
  localparam logic [IW-1:0] c_last_idx = IW'(N - 1);
  localparam logic [IW:0]   c_n        = (IW + 1)'(N);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_owner;
  logic [15:0]   r_cnt;
  logic          r_down_valid;
  logic [DW-1:0] r_down_data;
  logic [IW-1:0] r_down_src;

  logic          w_load_en;
  logic          w_any;
  logic          w_accept;
  logic          w_hold;
  logic [IW-1:0] w_next;
  logic [IW-1:0] w_sel;
  logic [DW-1:0] w_sel_data;
  logic [N-1:0]  w_up_ready;

  assign w_load_en = !r_down_valid || down_ready;
  assign w_any     = |up_valid;
  // Reset gates the grant so no upstream beat is consumed and then dropped.
  assign w_accept  = !rst && w_load_en && w_any;
  assign w_hold    = (r_state == ST_LOCKED) && up_valid[r_owner] && (r_cnt < c_burst);

  // Rotating search starting one past the owner; descending k lets the nearest win.
  always_comb begin : p_search
    logic [IW:0] v_idx;
    w_next = r_owner;
    v_idx  = '0;
    for (int k = N; k >= 1; k--) begin
      v_idx = {1'b0, r_owner} + (IW + 1)'(k);
      if (v_idx >= c_n) v_idx = v_idx - c_n;
      if (up_valid[v_idx[IW-1:0]]) w_next = v_idx[IW-1:0];
    end
  end

  assign w_sel = w_hold ? r_owner : w_next;

  always_comb begin
    w_sel_data = '0;
    w_up_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == IW'(i)) begin
        w_sel_data = up_data[i*DW +: DW];
        w_up_ready[i] = w_accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= c_last_idx;
      r_cnt        <= '0;
      r_down_valid <= 1'b0;
      r_down_data  <= '0;
      r_down_src   <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_down_valid <= 1'b1;
        r_down_data  <= w_sel_data;
        r_down_src   <= w_sel;
        if (w_hold) begin
          r_cnt <= r_cnt + 16'd1;
        end else begin
          r_owner <= w_sel;
          r_cnt   <= 16'd1;
          r_state <= ST_LOCKED;
        end
      end else begin
        r_down_valid <= 1'b0;
        r_state      <= ST_IDLE;
      end
    end
  end

  assign up_ready   = w_up_ready;
  assign down_valid = r_down_valid;
  assign down_data  = r_down_data;
  assign down_src   = r_down_src;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// Bench for stream_rr_arbiter: per-cycle comparison against a grant model,
// plus directed scenarios with hand-computed grants and source sequences.
module tb_stream_rr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int BURST = 2;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    up_valid = '0;
  logic [N-1:0]    up_ready;
  logic [N*DW-1:0] up_data = '0;
  logic            down_valid;
  logic            down_ready = 1'b0;
  logic [DW-1:0]   down_data;
  logic [IW-1:0]   down_src;

  stream_rr_arbiter #(.N(N), .DW(DW), .BURST(BURST), .IW(IW)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_src(down_src)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] seq     [N];
  logic [23:0] exp_seq [N];
  int          log_src [$];

  logic [N-1:0]  obs_ready;
  logic          obs_dvalid;
  logic [IW-1:0] obs_src;

  // Model: contents of the output register plus who owns the sink and for how long.
  bit            m_valid  = 1'b0;
  logic [DW-1:0] m_data   = '0;
  int            m_src    = 0;
  int            m_owner  = N - 1;
  int            m_run    = 0;
  bit            m_locked = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [N-1:0] v;
    int  g;
    bit  le;
    exp_ready = '0;
    g = -1;
    check("down_valid", 64'(down_valid), 64'(m_valid));
    if (m_valid) begin
      check("down_data", 64'(down_data), 64'(m_data));
      check("down_src", 64'(down_src), 64'(m_src));
    end
    check("ready_only_valid", 64'(up_ready & ~up_valid), 64'd0);
    le = !m_valid || down_ready;
    if (!rst && le && (|up_valid)) begin
      v = up_valid >> m_owner;
      if (m_locked && v[0] && m_run < BURST) begin
        g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          v = up_valid >> ((m_owner + k) % N);
          if (g < 0 && v[0]) g = (m_owner + k) % N;
        end
      end
      exp_ready = N'(1) << g;
    end
    check("up_ready", 64'(up_ready), 64'(exp_ready));
    if (!rst && m_valid && down_ready) begin
      check("src_order", 64'(down_data[23:0]), 64'(exp_seq[m_src]));
      exp_seq[m_src] = exp_seq[m_src] + 24'd1;
    end
    if (rst) begin
      if (m_valid) exp_seq[m_src] = exp_seq[m_src] + 24'd1;
      m_valid = 1'b0; m_data = '0; m_src = 0;
      m_owner = N - 1; m_run = 0; m_locked = 1'b0;
    end else if (le) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = DW'(up_data >> (g * DW));
        m_src   = g;
        if (m_locked && g == m_owner && m_run < BURST) begin
          m_run++;
        end else begin
          m_owner = g; m_run = 1; m_locked = 1'b1;
        end
      end else begin
        m_valid  = 1'b0;
        m_locked = 1'b0;
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic dr);
    up_valid   = v;
    down_ready = dr;
    up_data    = '0;
    for (int i = 0; i < N; i++)
      up_data = up_data | ((N*DW)'({8'(i), seq[i]}) << (i * DW));
    @(negedge clk);
    #1;
    obs_ready  = up_ready;
    obs_dvalid = down_valid;
    obs_src    = down_src;
    if (down_valid && down_ready) log_src.push_back(int'(down_src));
    for (int i = 0; i < N; i++)
      if (v[i] && up_ready[i]) seq[i] = seq[i] + 24'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fair_exp [9];
    fair_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int i = 0; i < N; i++) begin
      seq[i] = '0;
      exp_seq[i] = '0;
    end

    // Reset held with every requester asking.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 1'b1);
      check("rst_ready", 64'(obs_ready), 64'd0);
      check("rst_dvalid", 64'(obs_dvalid), 64'd0);
    end
    rst = 1'b0;
    step(4'b1111, 1'b1);
    check("release_dvalid", 64'(obs_dvalid), 64'd0);
    check("release_ready", 64'(obs_ready), 64'b0001);

    // Fairness with BURST=2.
    for (int c = 0; c < 9; c++) step(4'b1111, 1'b1);
    check("fair_count", 64'(log_src.size()), 64'd9);
    for (int i = 0; i < 9 && i < log_src.size(); i++)
      check("fair_src", 64'(log_src[i]), 64'(fair_exp[i]));

    // Back-pressure for 5 cycles, then release with no bubble.
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 1'b0);
      check("bp_ready", 64'(obs_ready), 64'd0);
      check("bp_dvalid", 64'(obs_dvalid), 64'd1);
    end
    step(4'b1111, 1'b1);
    check("bp_resume_ready", 64'(obs_ready), 64'b0010);

    // Lock held while owner valid, rotation at expiry, early release.
    step(4'b0000, 1'b1);
    check("idle_ready", 64'(obs_ready), 64'd0);
    step(4'b0010, 1'b1);
    check("own1_ready", 64'(obs_ready), 64'b0010);
    step(4'b1110, 1'b1);
    check("lock1_ready", 64'(obs_ready), 64'b0010);
    step(4'b1110, 1'b1);
    check("expire_ready", 64'(obs_ready), 64'b0100);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b1);
    check("own1b_ready", 64'(obs_ready), 64'b0010);
    step(4'b1100, 1'b1);
    check("early_rel_ready", 64'(obs_ready), 64'b0100);

    // Sole requester 3 for 6 beats.
    step(4'b1000, 1'b1);
    check("sole_ready", 64'(obs_ready), 64'b1000);
    log_src.delete();
    for (int c = 0; c < 5; c++) begin
      step(4'b1000, 1'b1);
      check("sole_ready", 64'(obs_ready), 64'b1000);
    end
    step(4'b0000, 1'b1);
    check("sole_count", 64'(log_src.size()), 64'd6);
    foreach (log_src[i]) check("sole_src", 64'(log_src[i]), 64'd3);

    // Sparse alternating requesters with random sink stalls.
    for (int c = 0; c < 200; c++)
      step((c % 2) ? 4'b0100 : 4'b0001, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);
    check("sparse_drained", 64'(obs_dvalid), 64'd0);

    // Reset while a beat is held under back-pressure.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    rst = 1'b1;
    step(4'b1111, 1'b0);
    rst = 1'b0;
    step(4'b1111, 1'b1);
    check("midrst_dvalid", 64'(obs_dvalid), 64'd0);
    check("midrst_ready", 64'(obs_ready), 64'b0001);
    step(4'b1111, 1'b1);
    check("midrst_first_valid", 64'(obs_dvalid), 64'd1);
    check("midrst_first_src", 64'(obs_src), 64'd0);
    step(4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
